// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if -- handshake/control bundle between a scan controller
// and the decode sequencer.
//   start, stop  : scan request / abort request (controller -> sequencer)
//   mode         : 0 = single pass, 1 = continuous
//   mask[3:0]    : decoder lines selected for the scan
//   dwell        : each selected line is enabled for dwell+1 cycles
//   address0/1   : address LSB/MSB to the downstream 2-to-4 decoder
//   enable       : decoder enable
//   busy         : scan in progress
//   done         : one-cycle pulse at scan end or abort
interface decode_sequencer_if #(
   parameter int DWELL_W = 4
) ();
   logic               start;
   logic               stop;
   logic               mode;
   logic [3:0]         mask;
   logic [DWELL_W-1:0] dwell;
   logic               address0;
   logic               address1;
   logic               enable;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, mode, mask, dwell,
      input  address0, address1, enable, busy, done
   );

   modport slave (
      input  start, stop, mode, mask, dwell,
      output address0, address1, enable, busy, done
   );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer -- scans the lines of a downstream 2-to-4 decoder.
// Each line selected in the latched mask is enabled for dwell+1 cycles, with a
// one-cycle enable-low gap in which the address moves to the next line
// (break-before-make). Single mode ends after the highest selected line;
// continuous mode wraps to the lowest selected line until stop.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : decode_sequencer_if.slave (start/stop/mode/mask/dwell in,
//           address0/address1/enable/busy/done out, all outputs registered)
module decode_sequencer #(
   parameter int DWELL_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   decode_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state;
   logic [3:0]         lmask;
   logic [DWELL_W-1:0] ldwell;
   logic               lmode;
   logic [DWELL_W-1:0] cnt;
   logic [1:0]         addr;
   logic               en_q;
   logic               busy_q;
   logic               done_q;

   // Lowest set index of a mask (0 when the mask is empty).
   function automatic logic [1:0] lowest_idx(input logic [3:0] m);
      lowest_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) lowest_idx = 2'(i);
      end
   endfunction

   // {found, index} of the lowest set bit strictly above cur.
   function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
      next_above = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) next_above = {1'b1, 2'(i)};
      end
   endfunction

   logic [1:0] low_in;
   logic [1:0] low_lat;
   logic [2:0] nxt;

   assign low_in  = lowest_idx(bus.mask);
   assign low_lat = lowest_idx(lmask);
   assign nxt     = next_above(lmask, addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         lmask  <= 4'd0;
         ldwell <= '0;
         lmode  <= 1'b0;
         cnt    <= '0;
         addr   <= 2'd0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.mask != 4'd0) begin
                     // Address and enable move together here: the decoder
                     // was disabled in the previous cycle.
                     lmask  <= bus.mask;
                     ldwell <= bus.dwell;
                     lmode  <= bus.mode;
                     addr   <= low_in;
                     cnt    <= '0;
                     en_q   <= 1'b1;
                     busy_q <= 1'b1;
                     state  <= ACTIVE;
                  end else begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            ACTIVE: begin
               if (bus.stop) begin
                  en_q   <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else if (cnt == ldwell) begin
                  if (nxt[2]) begin
                     addr  <= nxt[1:0];
                     en_q  <= 1'b0;
                     state <= GAP;
                  end else if (lmode) begin
                     // Wrap; with a single-bit mask this reselects the same line.
                     addr  <= low_lat;
                     en_q  <= 1'b0;
                     state <= GAP;
                  end else begin
                     en_q   <= 1'b0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end else begin
                  cnt <= cnt + DWELL_W'(1);
               end
            end
            GAP: begin
               if (bus.stop) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt   <= '0;
                  en_q  <= 1'b1;
                  state <= ACTIVE;
               end
            end
            DONE: begin
               // start and stop are deliberately not looked at here.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.address0 = addr[0];
   assign bus.address1 = addr[1];
   assign bus.enable   = en_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer -- scoreboard bench for decode_sequencer.
// Stimulus pushes expected events (enable runs {addr,len} and done pulses);
// a negedge monitor reconstructs events from the DUT outputs and compares.
module tb_decode_sequencer;

   logic clk;
   logic rst_n;

   decode_sequencer_if #(.DWELL_W(4)) bus ();

   decode_sequencer #(.DWELL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #100 clk = ~clk;

   typedef struct packed {
      logic       is_done;
      logic [1:0] addr;
      logic [7:0] len;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   // monitor state
   int         en_cycles = 0;
   int         viol      = 0;
   int         run_len   = 0;
   int         gap_len   = 0;
   logic [1:0] run_addr  = 2'd0;
   logic [1:0] mon_addr;
   logic [1:0] prev_addr = 2'd0;
   logic       prev_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic sb_check(input ev_t got);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL sb_unexpected: got done=%0b addr=%0d len=%0d, nothing expected",
                  got.is_done, got.addr, got.len);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            bad++;
            $display("FAIL sb_event: got done=%0b addr=%0d len=%0d, expected done=%0b addr=%0d len=%0d",
                     got.is_done, got.addr, got.len, e.is_done, e.addr, e.len);
         end
      end
   endtask

   task automatic push_run(input logic [1:0] a, input int n);
      ev_t e;
      e.is_done = 1'b0;
      e.addr    = a;
      e.len     = 8'(n);
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      ev_t e;
      e.is_done = 1'b1;
      e.addr    = 2'd0;
      e.len     = 8'd0;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      ev_t got;
      mon_addr = {bus.address1, bus.address0};
      if (!rst_n) begin
         run_len = 0;
         gap_len = 0;
         prev_en = 1'b0;
      end else begin
         if (bus.enable) begin
            en_cycles++;
            // address moved under an enable that was already on
            if (prev_en && (mon_addr != prev_addr)) viol++;
            if (run_len == 0) begin
               if (gap_len != 0) chk("gap_len", gap_len, 1);
               run_addr = mon_addr;
            end
            run_len++;
            gap_len = 0;
         end else begin
            if (run_len != 0) begin
               got.is_done = 1'b0;
               got.addr    = run_addr;
               got.len     = 8'(run_len);
               sb_check(got);
               run_len = 0;
            end
            if (bus.busy) gap_len++;
            else          gap_len = 0;
         end
         if (bus.done) begin
            got.is_done = 1'b1;
            got.addr    = 2'd0;
            got.len     = 8'd0;
            sb_check(got);
            chk("done_busy_low", {31'd0, bus.busy}, 0);
         end
         prev_en   = bus.enable;
         prev_addr = mon_addr;
      end
   end

   task automatic start_scan(input logic [3:0] m, input logic [3:0] d, input logic md);
      @(negedge clk);
      bus.mask  = m;
      bus.dwell = d;
      bus.mode  = md;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_quiet(input string name, input int maxc);
      int i;
      for (i = 0; i < maxc; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !bus.busy && !bus.done) break;
      end
      chk(name, {31'd0, (i >= maxc)}, 0);
      repeat (4) @(negedge clk);
   endtask

   int en_base;
   int n2;

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.mask  = 4'd0;
      bus.dwell = 4'd0;
      #10;
      chk("reset_outs", {27'd0, bus.address1, bus.address0, bus.enable, bus.busy, bus.done}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single pass 1011, dwell 2
      en_base = en_cycles;
      push_run(2'd0, 3);
      push_run(2'd1, 3);
      push_run(2'd3, 3);
      push_done();
      start_scan(4'b1011, 4'd2, 1'b0);
      wait_quiet("t1_timeout", 60);
      chk("t1_en_total", en_cycles - en_base, 9);
      chk("t1_addr_hold", {29'd0, bus.address1, bus.address0, bus.enable}, 3'b110);

      // stop while idle does nothing
      @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_stop", {29'd0, bus.busy, bus.enable, bus.done}, 0);

      // continuous 0110, dwell 0, stop during second visit to line 2
      push_run(2'd1, 1);
      push_run(2'd2, 1);
      push_run(2'd1, 1);
      push_run(2'd2, 1);
      push_done();
      start_scan(4'b0110, 4'd0, 1'b1);
      n2 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.enable && {bus.address1, bus.address0} == 2'd2) n2++;
         if (n2 == 2) begin
            bus.stop = 1'b1;
            break;
         end
      end
      @(negedge clk);
      bus.stop = 1'b0;
      chk("t2_stop_seen", n2, 2);
      wait_quiet("t2_timeout", 20);
      chk("t2_enable_off", {31'd0, bus.enable}, 0);

      // empty mask
      push_done();
      @(negedge clk);
      bus.mask  = 4'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t3_done_only", {29'd0, bus.done, bus.busy, bus.enable}, 3'b100);
      wait_quiet("t3_timeout", 10);

      // inputs changed and start re-pulsed mid-scan
      push_run(2'd0, 2);
      push_run(2'd2, 2);
      push_done();
      start_scan(4'b0101, 4'd1, 1'b0);
      @(negedge clk);
      bus.mask  = 4'b1111;
      bus.dwell = 4'd3;
      bus.mode  = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_quiet("t4_timeout", 40);

      // asynchronous reset mid-ACTIVE, then a fresh scan
      start_scan(4'b1000, 4'd3, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #50;
      rst_n = 1'b0;
      #1;
      chk("t5_async", {27'd0, bus.address1, bus.address0, bus.enable, bus.busy, bus.done}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_run(2'd3, 2);
      push_done();
      start_scan(4'b1000, 4'd1, 1'b0);
      wait_quiet("t5_timeout", 30);

      chk("bbm_violations", viol, 0);
      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, meaning the width of the dwell-count input and internal dwell counter.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a scan, sampled at a rising edge.
REQ-005 The block SHALL have port stop, input, 1, a request to abort a scan in progress.
REQ-006 The block SHALL have port mode, input, 1: 0 = single pass, 1 = continuous.
REQ-007 The block SHALL have port mask, input, 4: bit i = 1 selects decoder line i for the scan.
REQ-008 The block SHALL have port dwell, input, DWELL_W: each selected line is enabled for dwell+1 cycles.
REQ-009 The block SHALL have port address0, output, 1, the address LSB to the downstream 2-to-4 decoder.
REQ-010 The block SHALL have port address1, output, 1, the address MSB to the downstream 2-to-4 decoder.
REQ-011 The block SHALL have port enable, output, 1, the decoder enable.
REQ-012 The block SHALL have port busy, output, 1, high from scan acceptance until the DONE state.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse at scan end or abort.

Function
REQ-014 The block SHALL register every output, with no combinational path from any input to any output.
REQ-015 The block SHALL implement the states IDLE, ACTIVE, GAP and DONE.
REQ-016 In IDLE, when start=1 and mask!=0, the block SHALL latch mask, dwell and mode, set the address to the lowest set mask index, and enter ACTIVE at that same edge, so enable=1 and busy=1 in the following cycle.
REQ-017 In IDLE, when start=1 and mask=0, the block SHALL enter DONE (done pulse, enable never asserted).
REQ-018 The block SHALL ignore start while busy=1.
REQ-019 The block SHALL ignore changes to mask, dwell and mode while busy=1, using only the latched copies.
REQ-020 In ACTIVE, enable SHALL be 1 and the dwell counter SHALL count from 0; when the counter equals the latched dwell, the block SHALL enter GAP.
REQ-021 On entry to GAP, enable SHALL drop to 0 and the address SHALL update to the next set latched-mask index above the current one (break-before-make).
REQ-022 The address SHALL change only in cycles where enable=0.
REQ-023 GAP SHALL last exactly 1 cycle and then return to ACTIVE.
REQ-024 In single mode, when no higher set index exists, the block SHALL go ACTIVE -> DONE, leaving the address unchanged and enable=0.
REQ-025 In continuous mode, when no higher set index exists, the block SHALL wrap to the lowest set index through GAP.
REQ-026 With a single-bit mask in continuous mode, the block SHALL repeat ACTIVE(dwell+1) -> GAP(1) on the same address.
REQ-027 When stop=1 is sampled in ACTIVE or GAP, the block SHALL enter DONE at that edge, with enable=0 in the next cycle.
REQ-028 stop SHALL take priority over the dwell-expiry and next-line transitions at the same edge.
REQ-029 stop SHALL be ignored in IDLE and DONE.
REQ-030 DONE SHALL last 1 cycle with done=1, busy=0 and enable=0, then go to IDLE.
REQ-031 start sampled in the DONE cycle SHALL be ignored.
REQ-032 In single mode, the total enable-high cycles SHALL equal popcount(mask) x (dwell+1).
REQ-033 The dwell counter SHALL saturate-compare only (no wrap past dwell); dwell=0 SHALL give 1-cycle enable pulses.
REQ-034 The clock period SHALL be at least 200 time units, exceeding the downstream decoder's two 50-unit gate levels.

Reset
REQ-035 rst_n=0 SHALL immediately, without a clock, force: state IDLE, address0=0, address1=0, enable=0, busy=0, done=0, dwell counter 0, latched mask 0.
REQ-036 Reset asserted mid-scan SHALL abort with no done pulse; after release the first start SHALL begin a fresh scan.
REQ-037 The block SHALL require start to be sampled at least one edge after rst_n deasserts.

Verification
REQ-038 Single pass: mask=4'b1011, dwell=2, mode=0, start pulse -> addresses 0,1,3 with enable high 3 cycles each, 1-cycle low gaps, 9 enable cycles total, then done for 1 cycle, busy low.
REQ-039 Continuous wrap: mask=4'b0110, dwell=0, mode=1 -> address sequence 1,2,1,2,... with enable alternating 1/0 every cycle; stop during address 2 -> enable 0 next cycle, done pulse, no further enable.
REQ-040 Empty mask: mask=0, start -> done=1 one cycle later, enable and busy remain 0.
REQ-041 Start while busy plus input changes mid-scan: mask, dwell and mode changed during the scan and start re-pulsed -> scan follows the latched values unchanged and exactly one done pulse occurs.
REQ-042 Async reset: rst_n low mid-ACTIVE between clock edges -> enable, address and busy go 0 immediately, no done pulse; a post-reset start with mask=4'b1000 -> address 3, enable high.
REQ-043 Break-before-make check: a monitor over all scans flags any cycle where the address changes while enable=1 (zero violations required).
